// File: rtl/morty_pkg.sv
// Shared definitions for the fetch front end: data width, reset/NOP constants
// and the FIFO entry type pairing a fetched word with its PC.
package morty_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSN         = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] insn;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order circular buffer of fetched {pc, insn} entries; pointers wrap
// modulo DEPTH so non-power-of-two depths are supported.
module fetch_fifo
  import morty_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  input  logic          flush,
  output fetch_entry_t  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  fetch_entry_t  mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          pop_s;
  logic          push_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + 1'b1;
    end
  endfunction

  assign empty  = (count_r == '0);
  assign full   = (count_r == CW'(DEPTH));
  assign count  = count_r;
  assign head   = mem_r[rd_ptr_r];
  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign pop_s  = pop && !empty;
  assign push_s = push && (!full || pop_s);

  // Entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_s && !flush) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Read/write pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/if_stage_checker.sv
// Protocol checks for the fetch stage: responses only while requests are
// outstanding, and the credit scheme never overflows the fetch FIFO.
module if_stage_checker #(
  parameter int CW = 2
) (
  input logic          clk,
  input logic          rst_n,
  input logic          imem_rvalid,
  input logic [CW-1:0] outstanding,
  input logic          fifo_full,
  input logic          push,
  input logic          pop
);

  rvalid_needs_outstanding: assert property (
    @(posedge clk) disable iff (!rst_n) imem_rvalid |-> (outstanding != '0)
  );

  no_fifo_overflow: assert property (
    @(posedge clk) disable iff (!rst_n) (push && fifo_full) |-> pop
  );

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: fetch PC, request credits, late-response dropping
// after redirects, and the decoder-facing output. Option: FETCH_BYPASS_EN.
module if_stage
  import morty_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = morty_pkg::RESET_PC_DEFAULT,
  parameter int              DEPTH    = 2,
  parameter logic [XLEN-1:0] NOP_INSN = morty_pkg::NOP_INSN
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_stall,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instruction,
  output logic            if_valid
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] fetch_pc_r;
  logic [XLEN-1:0] resp_pc_r;
  logic [XLEN-1:0] last_pc_r;
  logic [CW-1:0]   outstanding_r;
  logic [CW-1:0]   drop_cnt_r;
  logic            run_r;

  logic [CW-1:0]   fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  fetch_entry_t    fifo_head;
  fetch_entry_t    push_data_s;

  logic [CW:0]     inflight_s;
  logic            credit_ok_s;
  logic            accept_s;
  logic            rsp_s;
  logic            drop_s;
  logic            keep_s;
  logic            bypass_s;
  logic            push_s;
  logic            pop_s;
  logic [CW-1:0]   outstanding_next_s;

  // Buffered plus in-flight words may never exceed the FIFO depth.
  assign inflight_s  = {1'b0, fifo_count} + {1'b0, outstanding_r};
  assign credit_ok_s = (inflight_s < (CW+1)'(DEPTH));
  assign imem_req    = run_r && !redirect_valid && credit_ok_s;
  assign imem_addr   = fetch_pc_r;
  assign accept_s    = imem_req && imem_ready;

  // A stray response with nothing outstanding leaves all state untouched.
  assign rsp_s       = imem_rvalid && (outstanding_r != '0);
  assign drop_s      = rsp_s && (drop_cnt_r != '0);
  assign keep_s      = rsp_s && (drop_cnt_r == '0) && !redirect_valid;

`ifdef FETCH_BYPASS_EN
  assign bypass_s    = keep_s && fifo_empty;
`else
  assign bypass_s    = 1'b0;
`endif

  assign push_s      = keep_s && !(bypass_s && !id_stall);
  assign pop_s       = !fifo_empty && !id_stall && !redirect_valid;
  assign push_data_s = '{pc: resp_pc_r, insn: imem_rdata};

  // In-flight request count after this cycle's acceptance and response.
  always_comb begin
    outstanding_next_s = outstanding_r;
    case ({accept_s, rsp_s})
      2'b10:   outstanding_next_s = outstanding_r + 1'b1;
      2'b01:   outstanding_next_s = outstanding_r - 1'b1;
      default: outstanding_next_s = outstanding_r;
    endcase
  end

  // Decoder-facing view: FIFO head, bypassed response, or NOP with held pc.
  always_comb begin
    if_valid    = 1'b0;
    instruction = NOP_INSN;
    pc          = last_pc_r;
    if (redirect_valid) begin
      if_valid    = 1'b0;
    end else if (!fifo_empty) begin
      if_valid    = 1'b1;
      instruction = fifo_head.insn;
      pc          = fifo_head.pc;
    end else if (bypass_s) begin
      if_valid    = 1'b1;
      instruction = imem_rdata;
      pc          = resp_pc_r;
    end else begin
      if_valid    = 1'b0;
    end
  end

  // Fetch/response PCs, credit counter and post-redirect drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_r         <= 1'b0;
      fetch_pc_r    <= RESET_PC;
      resp_pc_r     <= RESET_PC;
      last_pc_r     <= RESET_PC;
      outstanding_r <= '0;
      drop_cnt_r    <= '0;
    end else begin
      run_r         <= 1'b1;
      last_pc_r     <= pc;
      outstanding_r <= outstanding_next_s;
      if (redirect_valid) begin
        // Everything still in flight belongs to the old path.
        fetch_pc_r <= word_align(redirect_pc);
        resp_pc_r  <= word_align(redirect_pc);
        drop_cnt_r <= outstanding_next_s;
      end else begin
        if (accept_s) begin
          fetch_pc_r <= fetch_pc_r + 32'd4;
        end
        if (drop_s) begin
          drop_cnt_r <= drop_cnt_r - 1'b1;
        end else if (keep_s) begin
          resp_pc_r  <= resp_pc_r + 32'd4;
        end
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .flush     (redirect_valid),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  if_stage_checker #(
    .CW (CW)
  ) u_checker (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_rvalid (imem_rvalid),
    .outstanding (outstanding_r),
    .fifo_full   (fifo_full),
    .push        (push_s),
    .pop         (pop_s)
  );

endmodule
